// File: rtl/mips_mc_control.sv
// mips_mc_control
// Multicycle control FSM for the MIPS core. Sequences fetch, decode, execute,
// memory and writeback. Every datapath enable, the ALU operation code and the
// ALU operand selects come from here. Mult/div holds the execute state for
// MULDIV_CYCLES cycles.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (all outputs forced to 0 while high)
//   opcode        IR[31:26], sampled only in DECODE
//   funct         IR[5:0], sampled only in DECODE
//   zero          ALU zero flag (the PC qualification happens in the datapath)
//   alu_con       ALU operation code
//   alu_src_a     0=PC, 1=reg A
//   alu_src_b     0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//   pc_write      unconditional PC load
//   pc_write_cond PC load qualified by zero
//   pc_source     0=ALU result, 1=ALUOut, 2=jump target
//   i_or_d        0=PC address, 1=ALUOut address
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   ir_write      IR load
//   reg_dst       0=rt, 1=rd
//   mem_to_reg    0=ALUOut, 1=MDR
//   reg_write     register file write
//   illegal       one-cycle pulse on an unsupported opcode or funct
//   state         current state encoding (debug)
module mips_mc_control #(
   parameter int          MULDIV_CYCLES = 4,
   parameter logic [3:0]  ALU_ADD       = 4'b0000,
   parameter logic [3:0]  ALU_SUB       = 4'b0001,
   parameter logic [3:0]  ALU_MUL       = 4'b0010,
   parameter logic [3:0]  ALU_DIV       = 4'b0011,
   parameter logic [3:0]  ALU_SLT       = 4'b0100
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic [3:0] alu_con,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11,
      S_ILLEGAL   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   // Values below 1 behave as 1; the counter only has to reach MD-1.
   localparam int MD    = (MULDIV_CYCLES < 1) ? 1 : MULDIV_CYCLES;
   localparam int CNT_W = (MD < 2) ? 1 : $clog2(MD);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]       op_q, op_d;
   logic [5:0]       funct_q, funct_d;

   // The zero flag qualifies pc_write_cond inside the datapath, not here.
   logic unused_zero;
   assign unused_zero = zero;

   function automatic logic funct_supported(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_MULT) ||
             (fn == FN_DIV) || (fn == FN_SLT);
   endfunction

   function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
      logic [3:0] code;
      code = ALU_ADD;
      case (fn)
         FN_SUB:  code = ALU_SUB;
         FN_MULT: code = ALU_MUL;
         FN_DIV:  code = ALU_DIV;
         FN_SLT:  code = ALU_SLT;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   logic is_muldiv;
   assign is_muldiv = (funct_q == FN_MULT) || (funct_q == FN_DIV);

   // Next-state, cycle counter and decode-time field capture
   always_comb begin
      state_d = S_FETCH;
      cnt_d   = '0;
      op_d    = op_q;
      funct_d = funct_q;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            // Later states work from the latched copies only.
            op_d    = opcode;
            funct_d = funct;
            case (opcode)
               OP_RTYPE:     state_d = funct_supported(funct) ? S_R_EXEC : S_ILLEGAL;
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_I_EXEC;
               default:      state_d = S_ILLEGAL;
            endcase
         end
         S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  state_d = S_MEM_WB;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = S_FETCH;
         S_R_EXEC: begin
            if (is_muldiv && (cnt_q < CNT_LAST)) begin
               state_d = S_R_EXEC;
               cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end else begin
               state_d = S_R_WB;
               cnt_d   = '0;
            end
         end
         S_R_WB:    state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_I_EXEC:  state_d = S_I_WB;
         S_I_WB:    state_d = S_FETCH;
         S_ILLEGAL: state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         op_q    <= '0;
         funct_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         funct_q <= funct_d;
      end
   end

   // Moore output decode; reset overrides everything so no strobe can fire
   // in a reset cycle even if the registered state is mid-instruction.
   always_comb begin
      alu_con       = ALU_ADD;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'd0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'd0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal       = 1'b0;
      state         = reset ? 4'd0 : state_q;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               ir_write  = 1'b1;
               alu_src_b = 2'd1;
               pc_write  = 1'b1;
            end
            S_DECODE: alu_src_b = 2'd3;
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            S_MEM_READ: begin
               mem_read = 1'b1;
               i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_write = 1'b1;
               i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
               alu_src_a = 1'b1;
               alu_con   = alu_of_funct(funct_q);
            end
            S_R_WB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               alu_con   = alu_of_funct(funct_q);
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_con       = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = 2'd1;
            end
            S_JUMP: begin
               pc_write  = 1'b1;
               pc_source = 2'd2;
            end
            S_I_EXEC: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'd2;
            end
            S_I_WB:    reg_write = 1'b1;
            S_ILLEGAL: illegal   = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control
// Directed-vector bench for mips_mc_control. Each instruction is described by
// its expected state sequence; every cycle the state and the full control word
// are compared against hand-derived values.
module tb_mips_mc_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic [3:0] alu_con;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_source;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_dst;
   logic       mem_to_reg;
   logic       reg_write;
   logic       illegal;
   logic [3:0] state;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mips_mc_control dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .funct        (funct),
      .zero         (zero),
      .alu_con      (alu_con),
      .alu_src_a    (alu_src_a),
      .alu_src_b    (alu_src_b),
      .pc_write     (pc_write),
      .pc_write_cond(pc_write_cond),
      .pc_source    (pc_source),
      .i_or_d       (i_or_d),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .ir_write     (ir_write),
      .reg_dst      (reg_dst),
      .mem_to_reg   (mem_to_reg),
      .reg_write    (reg_write),
      .illegal      (illegal),
      .state        (state)
   );

   // Control word: {alu_con, src_a, src_b, pc_write, pc_write_cond, pc_source,
   //                i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
   //                reg_write, illegal}
   logic [18:0] ctl;
   assign ctl = {alu_con, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_source,
                 i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, illegal};

   // Hand-written expected control word per state; rcode is the ALU code the
   // instruction under test should show in R_EXEC/R_WB.
   function automatic logic [18:0] exp_ctl(input logic [3:0] st, input logic [3:0] rcode);
      case (st)
         4'd0:  return {4'b0000, 1'b0, 2'd1, 1'b1, 1'b0, 2'd0, 8'b0_1_0_1_0_0_0_0};
         4'd1:  return {4'b0000, 1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_0_0_0};
         4'd2:  return {4'b0000, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_0_0_0};
         4'd3:  return {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b1_1_0_0_0_0_0_0};
         4'd4:  return {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_1_1_0};
         4'd5:  return {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b1_0_1_0_0_0_0_0};
         4'd6:  return {rcode,   1'b1, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_0_0_0};
         4'd7:  return {rcode,   1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_1_0_1_0};
         4'd8:  return {4'b0001, 1'b1, 2'd0, 1'b0, 1'b1, 2'd1, 8'b0_0_0_0_0_0_0_0};
         4'd9:  return {4'b0000, 1'b0, 2'd0, 1'b1, 1'b0, 2'd2, 8'b0_0_0_0_0_0_0_0};
         4'd10: return {4'b0000, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_0_0_0};
         4'd11: return {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_0_1_0};
         4'd12: return {4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 8'b0_0_0_0_0_0_0_1};
         default: return 19'd0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered at a negedge with the DUT in FETCH. seq holds one expected state
   // per nibble, first state in the low nibble. The fields are driven during
   // FETCH and scrambled once DECODE is over.
   task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input int n, input logic [31:0] seq, input logic [3:0] rcode);
      logic [3:0] st;
      for (int i = 0; i < n; i++) begin
         st = seq[i*4 +: 4];
         #1;
         chk($sformatf("%s c%0d state", tag, i), {28'd0, state}, {28'd0, st});
         chk($sformatf("%s c%0d ctl", tag, i), {13'd0, ctl}, {13'd0, exp_ctl(st, rcode)});
         if (i == 0) begin
            opcode = op;
            funct  = fn;
         end else if (i == 2) begin
            opcode = ~op;
            funct  = ~fn;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset  = 1'b1;
      opcode = 6'h00;
      funct  = 6'h00;
      zero   = 1'b0;

      // Power-on reset: outputs all zero while held.
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("por state", {28'd0, state}, 32'd0);
         chk("por ctl", {13'd0, ctl}, 32'd0);
      end
      @(negedge clk);
      reset = 1'b0;

      run("sub",  6'h00, 6'h22, 4, 32'h0000_7610, 4'b0001);
      run("mult", 6'h00, 6'h18, 7, 32'h0766_6610, 4'b0010);
      run("div",  6'h00, 6'h1A, 7, 32'h0766_6610, 4'b0011);
      run("add",  6'h00, 6'h20, 4, 32'h0000_7610, 4'b0000);
      run("slt",  6'h00, 6'h2A, 4, 32'h0000_7610, 4'b0100);
      zero = 1'b1;
      run("beq",  6'h04, 6'h00, 3, 32'h0000_0810, 4'b0000);
      zero = 1'b0;
      run("lw",   6'h23, 6'h11, 5, 32'h0004_3210, 4'b0000);
      run("sw",   6'h2B, 6'h11, 4, 32'h0000_5210, 4'b0000);
      run("j",    6'h02, 6'h00, 3, 32'h0000_0910, 4'b0000);
      run("addi", 6'h08, 6'h22, 4, 32'h0000_BA10, 4'b0000);
      run("ilop", 6'h3F, 6'h20, 3, 32'h0000_0C10, 4'b0000);
      run("ilfn", 6'h00, 6'h07, 3, 32'h0000_0C10, 4'b0000);
      run("post", 6'h00, 6'h20, 4, 32'h0000_7610, 4'b0000);

      // Reset arriving in MEM_READ of a lw aborts it with no writeback.
      run("lwr", 6'h23, 6'h00, 3, 32'h0000_0210, 4'b0000);
      #1;
      chk("lwr memread state", {28'd0, state}, 32'd3);
      chk("lwr memread ctl", {13'd0, ctl}, {13'd0, exp_ctl(4'd3, 4'd0)});
      reset = 1'b1;
      #1;
      chk("rst0 ctl", {13'd0, ctl}, 32'd0);
      chk("rst0 state", {28'd0, state}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("rst ctl", {13'd0, ctl}, 32'd0);
         chk("rst rwrite", {31'd0, reg_write}, 32'd0);
      end
      reset = 1'b0;
      #1;
      chk("rel state", {28'd0, state}, 32'd0);
      chk("rel ctl", {13'd0, ctl}, {13'd0, exp_ctl(4'd0, 4'd0)});
      @(negedge clk);
      #1;
      chk("rel next state", {28'd0, state}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
